// File: rtl/mxint8_alu_sequencer.sv
// Sequences one MXINT8 block operation through a lane-limited element ALU: slices operands
// into beats, gathers in-order responses, and presents result scale, elements and zero count.
module mxint8_alu_sequencer #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    parameter int LANES       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [1:0]                       in_op,
    input  logic [SCALE_WIDTH-1:0]           in_scale_a,
    input  logic [SCALE_WIDTH-1:0]           in_scale_b,
    input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] in_elems_a,
    input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] in_elems_b,
    output logic                             alu_req_valid,
    input  logic                             alu_req_ready,
    output logic [1:0]                       alu_req_op,
    output logic [LANES*ELEM_WIDTH-1:0]      alu_req_a,
    output logic [LANES*ELEM_WIDTH-1:0]      alu_req_b,
    input  logic                             alu_rsp_valid,
    input  logic [LANES*ELEM_WIDTH-1:0]      alu_rsp_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SCALE_WIDTH-1:0]           out_scale,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] out_elems,
    output logic [$clog2(BLOCK_SIZE):0]      out_zero_num,
    output logic                             out_err
);

    localparam int BEATS     = BLOCK_SIZE / LANES;
    localparam int BEAT_W    = LANES * ELEM_WIDTH;
    localparam int BLK_W     = BLOCK_SIZE * ELEM_WIDTH;
    localparam int CNT_W     = $clog2(BEATS + 1);
    localparam int ZERO_W    = $clog2(BLOCK_SIZE) + 1;
    localparam int SUM_W     = SCALE_WIDTH + 2;
    localparam int BIAS      = (1 << (SCALE_WIDTH - 1)) - 1;
    localparam int SCALE_MAX = (1 << SCALE_WIDTH) - 2;
    localparam logic [SCALE_WIDTH-1:0] SCALE_NAN = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [BLK_W-1:0]         elems_a_q, elems_a_d, elems_b_q, elems_b_d;
    logic [BLK_W-1:0]         res_q, res_d;
    logic [SCALE_WIDTH-1:0]   scale_q, scale_d;
    logic                     err_q, err_d;
    logic [ZERO_W-1:0]        zero_q, zero_d;
    logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d, rsp_cnt_q, rsp_cnt_d;

    logic [SUM_W-1:0]         scale_sum;
    logic [SCALE_WIDTH-1:0]   mul_scale;
    logic [ZERO_W-1:0]        rsp_zeros;
    logic                     bad_block, rsp_fire, rsp_last, req_fire;

    // Biased exponents add, so one bias is removed; NaN dominates, result clamps below NaN.
    always_comb begin
        scale_sum = SUM_W'(in_scale_a) + SUM_W'(in_scale_b);
        if (in_scale_a == SCALE_NAN || in_scale_b == SCALE_NAN)
            mul_scale = SCALE_NAN;
        else if (scale_sum < SUM_W'(BIAS))
            mul_scale = '0;
        else if (scale_sum - SUM_W'(BIAS) > SUM_W'(SCALE_MAX))
            mul_scale = SCALE_WIDTH'(SCALE_MAX);
        else
            mul_scale = SCALE_WIDTH'(scale_sum - SUM_W'(BIAS));
        bad_block = (in_op == 2'b11) || (in_op == 2'b01 && in_scale_a != in_scale_b);
    end

    always_comb begin
        alu_req_a = '0;
        alu_req_b = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (issue_cnt_q == CNT_W'(k)) begin
                alu_req_a = elems_a_q[k*BEAT_W +: BEAT_W];
                alu_req_b = elems_b_q[k*BEAT_W +: BEAT_W];
            end
        end
        rsp_zeros = '0;
        for (int l = 0; l < LANES; l++) begin
            if (alu_rsp_data[l*ELEM_WIDTH +: ELEM_WIDTH] == '0)
                rsp_zeros = rsp_zeros + ZERO_W'(1);
        end
    end

    // Responses are only meaningful while a block is in flight; elsewhere they are dropped.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        elems_a_d   = elems_a_q;
        elems_b_d   = elems_b_q;
        res_d       = res_q;
        scale_d     = scale_q;
        err_d       = err_q;
        zero_d      = zero_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;

        req_fire = (state_q == ISSUE) && alu_req_ready;
        rsp_fire = alu_rsp_valid && (state_q == ISSUE || state_q == DRAIN);
        rsp_last = rsp_fire && (rsp_cnt_q == CNT_W'(BEATS - 1));

        if (rsp_fire) begin
            for (int k = 0; k < BEATS; k++) begin
                if (rsp_cnt_q == CNT_W'(k))
                    res_d[k*BEAT_W +: BEAT_W] = alu_rsp_data;
            end
            zero_d    = zero_q + rsp_zeros;
            rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d        = in_op;
                    elems_a_d   = in_elems_a;
                    elems_b_d   = in_elems_b;
                    res_d       = '0;
                    issue_cnt_d = '0;
                    rsp_cnt_d   = '0;
                    if (bad_block) begin
                        err_d   = 1'b1;
                        scale_d = SCALE_NAN;
                        zero_d  = ZERO_W'(BLOCK_SIZE);
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        scale_d = (in_op == 2'b10) ? mul_scale : in_scale_a;
                        zero_d  = '0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == CNT_W'(BEATS - 1))
                        state_d = rsp_last ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_last)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            elems_a_q   <= '0;
            elems_b_q   <= '0;
            res_q       <= '0;
            scale_q     <= '0;
            err_q       <= 1'b0;
            zero_q      <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            elems_a_q   <= elems_a_d;
            elems_b_q   <= elems_b_d;
            res_q       <= res_d;
            scale_q     <= scale_d;
            err_q       <= err_d;
            zero_q      <= zero_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign alu_req_valid = (state_q == ISSUE);
    assign out_valid     = (state_q == DONE);
    assign alu_req_op    = op_q;
    assign out_scale     = scale_q;
    assign out_elems     = res_q;
    assign out_zero_num  = zero_q;
    assign out_err       = err_q;

endmodule
